// File: rtl/main_pkg.sv
// Shared types for the wall-following robot controller.
// State encoding and turn-sequence length.
package main_pkg;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    FOLLOW    = 2'd1,
    TURN_LEFT = 2'd2,
    GAP_FWD   = 2'd3
  } state_t;

  localparam logic [1:0] TURN_LEFT_ROTATIONS = 2'd3;

endpackage

// File: rtl/main_tick_divider.sv
// Prescaler: one-cycle decision tick every
// CLK_FREQUENCY input clock cycles.
module tick_divider #(
  parameter int CLK_FREQUENCY = 5
) (
  input  logic initial_clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [31:0] LP_LAST = 32'(CLK_FREQUENCY - 1);

  logic [31:0] r_count;

  assign tick = (r_count == LP_LAST);

  // Free-running count, wraps on the tick cycle
  always_ff @(posedge initial_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: rtl/main.sv
// Left-hand-rule wall follower: one front or
// rotate command per decision tick.
module main
  import main_pkg::*;
#(
  parameter int CLK_FREQUENCY = 5
) (
  input  logic initial_clk,
  input  logic rst_n,
  input  logic head,
  input  logic left,
  output logic front,
  output logic rotate
);

  logic       w_tick;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_turns;
  logic [1:0] w_turns_nxt;
  logic [1:0] w_turns_inc;
  logic       w_front_nxt;
  logic       w_rotate_nxt;

  tick_divider #(
    .CLK_FREQUENCY(CLK_FREQUENCY)
  ) u_div (
    .initial_clk(initial_clk),
    .rst_n      (rst_n),
    .tick       (w_tick)
  );

  assign w_turns_inc = r_turns + 2'd1;

  // State, turn counter and commands advance only on tick
  always_ff @(posedge initial_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEARCH;
      r_turns <= 2'd0;
      front   <= 1'b0;
      rotate  <= 1'b0;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
      r_turns <= w_turns_nxt;
      front   <= w_front_nxt;
      rotate  <= w_rotate_nxt;
    end
  end

  // Next state and turn counter from sensors
  always_comb begin
    w_state_nxt = SEARCH;
    w_turns_nxt = 2'd0;
    case (r_state)
      SEARCH: begin
        if (head || left) w_state_nxt = FOLLOW;
        else              w_state_nxt = SEARCH;
      end
      FOLLOW: begin
        if (!head && !left) begin
          w_state_nxt = TURN_LEFT;
          w_turns_nxt = 2'd1;
        end else begin
          w_state_nxt = FOLLOW;
        end
      end
      TURN_LEFT: begin
        if (w_turns_inc == TURN_LEFT_ROTATIONS) begin
          w_state_nxt = GAP_FWD;
          w_turns_nxt = 2'd0;
        end else begin
          w_state_nxt = TURN_LEFT;
          w_turns_nxt = w_turns_inc;
        end
      end
      GAP_FWD: w_state_nxt = FOLLOW;
      default: w_state_nxt = SEARCH;
    endcase
  end

  // Movement command for the coming step
  always_comb begin
    w_front_nxt  = 1'b0;
    w_rotate_nxt = 1'b0;
    case (r_state)
      SEARCH: begin
        w_rotate_nxt = head;
        w_front_nxt  = !head;
      end
      FOLLOW: begin
        w_front_nxt  = !head && left;
        w_rotate_nxt = head || !left;
      end
      TURN_LEFT: w_rotate_nxt = 1'b1;
      GAP_FWD: begin
        w_rotate_nxt = head;
        w_front_nxt  = !head;
      end
      default: begin
        w_front_nxt  = 1'b0;
        w_rotate_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_main.sv
// Bench for the wall follower: directed ticks on a
// divide-by-5 instance, random steps on divide-by-1.
module tb_main;

  logic clk;
  logic rst_n;
  logic h5, l5, f5, r5;
  logic h1, l1, f1, r1;

  int total = 0;
  int bad   = 0;

  main #(.CLK_FREQUENCY(5)) dut5 (
    .initial_clk(clk), .rst_n(rst_n),
    .head(h5), .left(l5),
    .front(f5), .rotate(r5)
  );

  main #(.CLK_FREQUENCY(1)) dut1 (
    .initial_clk(clk), .rst_n(rst_n),
    .head(h1), .left(l1),
    .front(f1), .rotate(r1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: wall knowledge, pending
  // extra rotations of a left turn, and a gap step.
  bit m_known [2];
  int m_rem   [2];
  bit m_gap   [2];
  bit m_f     [2];
  bit m_r     [2];
  bit m_seen  [2];
  int m_cnt   [2];
  int m_div   [2];

  initial begin
    m_div[0] = 5;
    m_div[1] = 1;
  end

  task automatic model_tick(int k, bit h, bit l);
    bit mv;
    m_seen[k] = 1;
    if (m_rem[k] > 0) begin
      mv = 0;
      m_rem[k]--;
      if (m_rem[k] == 0) m_gap[k] = 1;
    end else if (m_gap[k]) begin
      m_gap[k] = 0;
      m_known[k] = 1;
      mv = !h;
    end else if (!m_known[k]) begin
      mv = !h;
      if (h || l) m_known[k] = 1;
    end else begin
      if (h) mv = 0;
      else if (l) mv = 1;
      else begin
        mv = 0;
        m_rem[k] = 2;
      end
    end
    m_f[k] = mv;
    m_r[k] = !mv;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_known[k] = 0; m_rem[k] = 0; m_gap[k] = 0;
        m_f[k] = 0; m_r[k] = 0; m_seen[k] = 0;
        m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_cnt[k] == m_div[k] - 1) begin
          m_cnt[k] = 0;
          if (k == 0) model_tick(0, h5, l5);
          else        model_tick(1, h1, l1);
        end else begin
          m_cnt[k]++;
        end
      end
    end
  end

  // Compare both instances against the model
  always @(negedge clk) begin
    total++;
    if (f5 !== m_f[0] || r5 !== m_r[0]) begin
      bad++;
      $display("FAIL model5 t=%0t got f=%b r=%b want f=%b r=%b",
               $time, f5, r5, m_f[0], m_r[0]);
    end
    total++;
    if (f1 !== m_f[1] || r1 !== m_r[1]) begin
      bad++;
      $display("FAIL model1 t=%0t got f=%b r=%b want f=%b r=%b",
               $time, f1, r1, m_f[1], m_r[1]);
    end
    total++;
    if ((f1 & r1) !== 1'b0) begin
      bad++;
      $display("FAIL excl t=%0t got f=%b r=%b want not both",
               $time, f1, r1);
    end
    if (m_seen[1]) begin
      total++;
      if ((f1 | r1) !== 1'b1) begin
        bad++;
        $display("FAIL onehot t=%0t got f=%b r=%b want one set",
                 $time, f1, r1);
      end
    end
  end

  // Random sensors for the divide-by-1 instance
  initial begin
    h1 = 0; l1 = 0;
    forever begin
      @(negedge clk);
      h1 = 1'($urandom_range(0, 1));
      l1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic lit(string name, bit ef, bit er);
    total++;
    if (f5 !== ef || r5 !== er) begin
      bad++;
      $display("FAIL %s got f=%b r=%b want f=%b r=%b",
               name, f5, r5, ef, er);
    end
  endtask

  task automatic tick5(string name, bit h, bit l,
                       bit ef, bit er);
    @(negedge clk);
    h5 = h; l5 = l;
    repeat (5) @(posedge clk);
    #1;
    lit(name, ef, er);
  endtask

  initial begin
    rst_n = 0; h5 = 0; l5 = 0;
    repeat (3) @(negedge clk);
    lit("reset", 0, 0);
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    lit("pre_tick", 0, 0);
    @(posedge clk);
    #1;
    lit("first_tick", 1, 0);
    repeat (4) @(posedge clk);
    #1;
    lit("hold", 1, 0);
    @(negedge clk);
    h5 = 1;
    @(posedge clk);
    #1;
    lit("search_corner", 0, 1);
    tick5("follow_a", 0, 1, 1, 0);
    tick5("follow_b", 0, 1, 1, 0);
    tick5("inside", 1, 1, 0, 1);
    tick5("lost", 0, 0, 0, 1);
    tick5("turn2", 1, 1, 0, 1);
    tick5("turn3", 1, 0, 0, 1);
    tick5("gap", 0, 1, 1, 0);
    tick5("back_follow", 0, 1, 1, 0);
    tick5("lost2", 0, 0, 0, 1);
    tick5("turn2b", 1, 1, 0, 1);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    lit("async_rst", 0, 0);
    @(negedge clk);
    h5 = 0; l5 = 0;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    lit("restart", 1, 0);
    tick5("restart_b", 0, 0, 1, 0);
    tick5("acquire", 0, 1, 1, 0);
    tick5("lost3", 0, 0, 0, 1);
    repeat (60) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
